led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl.sv | 80 ++++++++
 tb/tb_led_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/led_ctrl.sv
// led_ctrl: LED pattern driver with static, blink, chase and count display modes
module led_ctrl #(
  parameter int DATA_W   = 32,
  parameter int LED_W    = 8,
  parameter int LANE_W   = 2,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] datain,
  input  logic [LANE_W-1:0] lane,
  input  logic              mode_we,
  input  logic [1:0]        mode,
  output logic [LED_W-1:0]  dataout,
  output logic              tick
);
  localparam int NL = DATA_W / LED_W;
  localparam int DW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {M_STATIC, M_BLINK, M_CHASE, M_COUNT} mode_e;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  mode_e             mode_q, mode_d;
  logic [DW-1:0]     div_q, div_d;
  logic              phase_q, phase_d;
  logic [LED_W-1:0]  rot_q, rot_d;
  logic [LED_W-1:0]  cnt_q, cnt_d;
  logic [LED_W-1:0]  out_q, out_d;
  logic              tick_q;
  logic              wrap, adv;
  logic [LED_W-1:0]  pat;
  // Out-of-range lanes fall back to the lowest slice
  function automatic logic [LED_W-1:0] slice(input logic [DATA_W-1:0] d, input logic [LANE_W-1:0] l);
    slice = d[LED_W-1:0];
    for (int i = 1; i < NL; i++)
      if (l == LANE_W'(i)) slice = d[i*LED_W +: LED_W];
  endfunction
  // Next state: a mode write restarts the animation and wins over a coincident tick
  always_comb begin
    wrap    = div_q == DW'(TICK_DIV - 1);
    adv     = wrap && !mode_we;
    data_d  = we ? datain : data_q;
    lane_d  = we ? lane : lane_q;
    mode_d  = mode_we ? mode_e'(mode) : mode_q;
    div_d   = (mode_we || wrap) ? '0 : div_q + 1'b1;
    phase_d = mode_we ? 1'b1 : adv ? ~phase_q : phase_q;
    rot_d   = (we || mode_we) ? slice(data_d, lane_d) : adv ? (rot_q << 1) | (rot_q >> (LED_W - 1)) : rot_q;
    cnt_d   = mode_we ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
    pat     = slice(data_q, lane_q);
    out_d   = mode_q == M_STATIC ? pat :
              mode_q == M_BLINK  ? (phase_q ? pat : '0) :
              mode_q == M_CHASE  ? rot_q : cnt_q;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      lane_q  <= '0;
      mode_q  <= M_STATIC;
      div_q   <= '0;
      phase_q <= 1'b1;
      rot_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      lane_q  <= lane_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      tick_q  <= wrap;
    end
  end
  assign dataout = out_q;
  assign tick    = tick_q;
endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: scoreboard bench for led_ctrl with a short tick period
module tb_led_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] datain = '0;
  logic [1:0]  lane = '0;
  logic        mode_we = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  dataout;
  logic        tick;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    int         at;
    string      tag;
    bit         is_tick;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];
  logic [7:0] rot_exp [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
  led_ctrl #(.DATA_W(32), .LED_W(8), .LANE_W(2), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .datain(datain), .lane(lane),
    .mode_we(mode_we), .mode(mode), .dataout(dataout), .tick(tick)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // Outputs are compared on the falling edge, away from the active edge
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, sb[i].is_tick ? {31'd0, tick} : {24'd0, dataout}, {24'd0, sb[i].v});
        sb.delete(i);
      end else i++;
    end
  end
  task automatic drive(input logic r, input logic w, input logic [31:0] d, input logic [1:0] l,
                       input logic mw, input logic [1:0] m);
    @(negedge clk);
    rst_n = r; we = w; datain = d; lane = l; mode_we = mw; mode = m;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, $urandom, 2'($urandom), 1'b0, 2'($urandom));
  endtask
  task automatic expd(input int dly, input string tag, input logic [7:0] v);
    sb.push_back('{cyc + dly, tag, 1'b0, v});
  endtask
  task automatic expt(input int dly, input string tag, input logic v);
    sb.push_back('{cyc + dly, tag, 1'b1, {7'd0, v}});
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
      expd(1, $sformatf("rst_dout%0d", i), 8'h00);
      expt(1, $sformatf("rst_tick%0d", i), 1'b0);
    end
    drive(1'b1, 1'b1, 32'hA1B2C3D4, 2'd2, 1'b0, 2'd0);
    expd(1, "wr_latency", 8'h00);
    expd(2, "wr_lane2", 8'hB2);
    idle(2);
    drive(1'b1, 1'b0, $urandom, 2'($urandom), 1'b1, 2'd1);
    for (int k = 2; k <= 13; k++) begin
      expd(k, $sformatf("blink%0d", k), ((k - 2) / 4) % 2 == 0 ? 8'hB2 : 8'h00);
      expt(k, $sformatf("blink_tick%0d", k), (k - 1) % 4 == 0);
    end
    idle(13);
    drive(1'b1, 1'b1, 32'h00008100, 2'd1, 1'b0, 2'd0);
    drive(1'b1, 1'b0, $urandom, 2'($urandom), 1'b1, 2'd2);
    for (int k = 2; k <= 17; k++) expd(k, $sformatf("chase%0d", k), rot_exp[(k - 2) / 4]);
    idle(17);
    drive(1'b1, 1'b0, $urandom, 2'($urandom), 1'b1, 2'd3);
    for (int k = 2; k <= 13; k++) expd(k, $sformatf("count%0d", k), 8'((k - 2) / 4));
    expd(1021, "count_fe", 8'hFE);
    expd(1025, "count_ff", 8'hFF);
    expd(1026, "count_wrap", 8'h00);
    idle(1026);
    drive(1'b1, 1'b0, $urandom, 2'($urandom), 1'b1, 2'd2);
    idle(3);
    drive(1'b1, 1'b1, 32'h000000F0, 2'd0, 1'b1, 2'd2);
    for (int k = 2; k <= 9; k++) expd(k, $sformatf("coinc%0d", k), k < 6 ? 8'hF0 : 8'hE1);
    idle(9);
    drive(1'b1, 1'b0, $urandom, 2'($urandom), 1'b1, 2'd1);
    idle(6);
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 2'd0, 1'b1, 2'd2);
    for (int k = 1; k <= 6; k++) expd(k, $sformatf("midrst%0d", k), 8'h00);
    idle(5);
    drive(1'b1, 1'b1, 32'h0000005A, 2'd0, 1'b0, 2'd0);
    for (int k = 2; k <= 9; k++) expd(k, $sformatf("post_rst_static%0d", k), 8'h5A);
    idle(9);
    idle(1);
    #1;
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
